// File: rtl/and16_shared_arbiter_pkg.sv
// Shared constants and types for the two-requester AND arbiter.
// Build option AND16_ARB_RR_EN selects round-robin arbitration.
package and16_shared_arbiter_pkg;

  localparam int DEF_WIDTH = 16;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/and16_array.sv
// Purely combinational bitwise AND datapath.
// Shared by both requesters through the arbiter.
module and16_array #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  assign y = a & b;

endmodule

// File: rtl/and16_rr_grant.sv
// Two-way grant selector.
// AND16_ARB_RR_EN: round-robin, else requester 0 has fixed priority.
module and16_rr_grant
  import and16_shared_arbiter_pkg::*;
(
  input  logic       valid0,
  input  logic       valid1,
  input  logic       last_grant,
  output logic [1:0] gnt
);

`ifdef AND16_ARB_RR_EN
  logic [1:0] both_gnt;
  assign both_gnt = (last_grant == REQ0) ? 2'b10 : 2'b01;
`else
  logic [1:0] both_gnt;
  logic       unused_last_grant;
  assign both_gnt = 2'b01;
  assign unused_last_grant = last_grant;
`endif

  // one-hot grant from the valid pattern
  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      (valid0 & valid1):  gnt = both_gnt;
      (valid0 & ~valid1): gnt = 2'b01;
      (~valid0 & valid1): gnt = 2'b10;
      default:            gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/and16_shared_arbiter.sv
// Shares one AND array between two valid/ready requesters.
// AND16_ARB_RR_EN enables round-robin grant; default is fixed priority.
module and16_shared_arbiter
  import and16_shared_arbiter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_id,
  output logic             busy,
  output logic [CNT_W-1:0] op_count
);

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] and_y;
  logic             id_reg;
  logic             last_grant;
  logic [1:0]       gnt;

  and16_rr_grant u_grant (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  and16_array #(.WIDTH(WIDTH)) u_and (
    .a (op_a),
    .b (op_b),
    .y (and_y)
  );

  assign req0_ready = (state == IDLE) & gnt[0];
  assign req1_ready = (state == IDLE) & gnt[1];
  assign busy       = (state != IDLE);

  // accept -> compute -> hold result until consumed
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      id_reg     <= REQ0;
      last_grant <= REQ1;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_id     <= REQ0;
      op_count   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0_valid & req0_ready) begin
            op_a       <= req0_a;
            op_b       <= req0_b;
            id_reg     <= REQ0;
            last_grant <= REQ0;
            state      <= CALC;
          end else if (req1_valid & req1_ready) begin
            op_a       <= req1_a;
            op_b       <= req1_b;
            id_reg     <= REQ1;
            last_grant <= REQ1;
            state      <= CALC;
          end
        end
        CALC: begin
          rsp_data  <= and_y;
          rsp_id    <= id_reg;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            op_count  <= op_count + 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_and16_shared_arbiter.sv
// Directed bench for and16_shared_arbiter (CNT_W=4 to reach wrap).
// Expectations adapt to AND16_ARB_RR_EN.
module tb_and16_shared_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid, req0_ready;
  logic [15:0] req0_a, req0_b;
  logic        req1_valid, req1_ready;
  logic [15:0] req1_a, req1_b;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_data;
  logic        rsp_id;
  logic        busy;
  logic [3:0]  op_count;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  and16_shared_arbiter #(.WIDTH(16), .CNT_W(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_id     (rsp_id),
    .busy       (busy),
    .op_count   (op_count)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    req0_a = '0;
    req0_b = '0;
    req1_a = '0;
    req1_b = '0;
    rsp_ready = 1'b0;
  endtask

  task automatic do_reset();
    quiet();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", rsp_valid, 0);
    chk("rst_data", rsp_data, 0);
    chk("rst_id", rsp_id, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", op_count, 0);
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic do_op(input logic id, input logic [15:0] a,
                       input logic [15:0] b, input logic [15:0] exp);
    if (id) begin
      req1_valid = 1'b1;
      req1_a = a;
      req1_b = b;
    end else begin
      req0_valid = 1'b1;
      req0_a = a;
      req0_b = b;
    end
    #1;
    chk("op_ready", id ? req1_ready : req0_ready, 1);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("op_calc_valid", rsp_valid, 0);
    step();
    chk("op_valid", rsp_valid, 1);
    chk("op_data", rsp_data, exp);
    chk("op_id", rsp_id, id);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("op_done_valid", rsp_valid, 0);
  endtask

  initial begin
    logic exp_id;
    int   w;
    quiet();

    // single request plus backpressure
    do_reset();
    step();
    req0_valid = 1'b1;
    req0_a = 16'hF0F0;
    req0_b = 16'hFF00;
    #1;
    chk("t1_ready0", req0_ready, 1);
    chk("t1_ready1", req1_ready, 0);
    step();
    req0_valid = 1'b0;
    chk("t1_calc_valid", rsp_valid, 0);
    chk("t1_calc_busy", busy, 1);
    step();
    for (int i = 0; i < 5; i++) begin
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      #1;
      chk("bp_valid", rsp_valid, 1);
      chk("bp_data", rsp_data, 16'hF000);
      chk("bp_id", rsp_id, 0);
      chk("bp_ready", {req0_ready, req1_ready}, 0);
      chk("bp_busy", busy, 1);
      step();
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("t1_cnt", op_count, 1);
    chk("t1_idle_valid", rsp_valid, 0);
    chk("t1_idle_busy", busy, 0);

    // contention
    do_reset();
    req0_valid = 1'b1;
    req0_a = 16'hFFFF;
    req0_b = 16'h1234;
    req1_valid = 1'b1;
    req1_a = 16'hFFFF;
    req1_b = 16'hABCD;
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (!rsp_valid && w < 10) begin
        step();
        w++;
      end
      chk("cont_timeout", (w < 10), 1);
`ifdef AND16_ARB_RR_EN
      exp_id = (k % 2 == 1);
`else
      exp_id = 1'b0;
`endif
      chk("cont_id", rsp_id, exp_id);
      chk("cont_data", rsp_data, exp_id ? 16'hABCD : 16'h1234);
      step();
    end
    quiet();
    chk("cont_cnt", op_count, 4);

    // reset while in CALC
    req1_valid = 1'b1;
    req1_a = 16'h0F0F;
    req1_b = 16'h00FF;
    #1;
    chk("mid_ready1", req1_ready, 1);
    step();
    req1_valid = 1'b0;
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_valid", rsp_valid, 0);
    chk("mid_busy0", busy, 0);
    chk("mid_cnt", op_count, 0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_noreplay", rsp_valid, 0);
    end
    do_op(1'b0, 16'h00FF, 16'h0FF0, 16'h00F0);
    chk("mid_cnt1", op_count, 1);

    // valid withdrawal during RESP
    req0_valid = 1'b1;
    req0_a = 16'hAAAA;
    req0_b = 16'hFFFF;
    step();
    req0_valid = 1'b0;
    step();
    chk("wd_valid", rsp_valid, 1);
    req1_valid = 1'b1;
    req1_a = 16'hFFFF;
    req1_b = 16'hFFFF;
    #1;
    chk("wd_ready1", req1_ready, 0);
    step();
    req1_valid = 1'b0;
    chk("wd_id", rsp_id, 0);
    chk("wd_data", rsp_data, 16'hAAAA);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("wd_cnt", op_count, 2);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("wd_novalid", rsp_valid, 0);
      chk("wd_nobusy", busy, 0);
    end
    chk("wd_cnt_hold", op_count, 2);

    // counter wrap
    do_reset();
    for (int i = 0; i < 17; i++) begin
      do_op(i[0], 16'hFFFF, 16'(i * 16'h0101), 16'(i * 16'h0101));
      chk("wrap_cnt", op_count, (i + 1) % 16);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
